// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream input, imem write port and loader status.
// The slave side is the loader, the master side is the host/CPU wrapper.
interface imem_loader_if #(
    parameter int unsigned ADDR_WIDTH = 16
);
    logic [7:0]            in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic                  cpu_hold;
    logic                  load_done;
    logic                  load_err;

    modport master (
        output in_data, in_valid,
        input  in_ready, mem_we, mem_addr, mem_wdata,
        input  cpu_hold, load_done, load_err
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, mem_we, mem_addr, mem_wdata,
        output cpu_hold, load_done, load_err
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: boot loader turning a framed byte stream into imem writes.
// Define IMEM_LOADER_CHECKSUM_EN to expect and check a trailing XOR byte.
module imem_loader #(
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter logic [7:0]  MAGIC          = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input logic        clk,
    input logic        rst_n,
    imem_loader_if.slave bus
);
    localparam int unsigned   CW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] IDLE_MAX = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [16:0]   MAX_LEN  = 17'd1 << ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CSUM
    } state_e;

    state_e                state_q, state_d;
    logic [7:0]            len_lo_q, len_lo_d;
    logic [16:0]           words_q, words_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [1:0]            bidx_q, bidx_d;
    logic [23:0]           wbuf_q, wbuf_d;
    logic [CW-1:0]         idle_q, idle_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;
    logic                  cpu_hold_q, cpu_hold_d;
    logic                  load_done_q, load_done_d;
    logic                  load_err_q, load_err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]            csum_q, csum_d;
`endif

    logic        accept;
    logic        start;
    logic        finish;
    logic        fail;
    logic        timed;
    logic [15:0] len_full;

    assign bus.in_ready  = 1'b1;
    assign accept        = bus.in_valid & bus.in_ready;
    assign len_full      = {bus.in_data, len_lo_q};
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.cpu_hold  = cpu_hold_q;
    assign bus.load_done = load_done_q;
    assign bus.load_err  = load_err_q;

    // Without a checksum, CSUM is a one-cycle completion state, not a wait.
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign timed = (state_q != S_IDLE);
`else
    assign timed = (state_q == S_LEN0) || (state_q == S_LEN1) ||
                   (state_q == S_DATA);
`endif

    // Frame parser: next state, word assembly, write strobe and status.
    always_comb begin
        state_d     = state_q;
        len_lo_d    = len_lo_q;
        words_d     = words_q;
        waddr_d     = waddr_q;
        bidx_d      = bidx_q;
        wbuf_d      = wbuf_q;
        idle_d      = '0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_hold_d  = cpu_hold_q;
        load_done_d = load_done_q;
        load_err_d  = load_err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        start  = 1'b0;
        finish = 1'b0;
        fail   = 1'b0;

        if (timed && !accept) begin
            if (idle_q == IDLE_MAX) fail = 1'b1;
            else idle_d = idle_q + 1'b1;
        end

        unique case (state_q)
            S_IDLE: start = accept && (bus.in_data == MAGIC);
            S_LEN0: begin
                if (accept) begin
                    len_lo_d = bus.in_data;
                    state_d  = S_LEN1;
                end
            end
            S_LEN1: begin
                if (accept) begin
                    if ({1'b0, len_full} > MAX_LEN) begin
                        fail = 1'b1;
                    end else if (len_full == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_d = S_CSUM;
`else
                        finish = 1'b1;
`endif
                    end else begin
                        words_d = {1'b0, len_full};
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ bus.in_data;
`endif
                    bidx_d = bidx_q + 2'd1;
                    unique case (bidx_q)
                        2'd0: wbuf_d[7:0]   = bus.in_data;
                        2'd1: wbuf_d[15:8]  = bus.in_data;
                        2'd2: wbuf_d[23:16] = bus.in_data;
                        default: begin
                            mem_we_d    = 1'b1;
                            mem_addr_d  = waddr_q;
                            mem_wdata_d = {bus.in_data, wbuf_q};
                            waddr_d     = waddr_q + 1'b1;
                            words_d     = words_q - 17'd1;
                            if (words_q == 17'd1) state_d = S_CSUM;
                        end
                    endcase
                end
            end
            S_CSUM: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (accept) begin
                    if (bus.in_data == csum_q) finish = 1'b1;
                    else fail = 1'b1;
                end
`else
                finish = 1'b1;
                start  = accept && (bus.in_data == MAGIC);
`endif
            end
            default: state_d = S_IDLE;
        endcase

        if (finish) begin
            load_done_d = 1'b1;
            cpu_hold_d  = 1'b0;
            state_d     = S_IDLE;
        end
        if (fail) begin
            load_err_d = 1'b1;
            cpu_hold_d = 1'b1;
            state_d    = S_IDLE;
        end
        if (start) begin
            load_done_d = 1'b0;
            load_err_d  = 1'b0;
            cpu_hold_d  = 1'b1;
            waddr_d     = '0;
            bidx_d      = 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_d      = 8'd0;
`endif
            state_d     = S_LEN0;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            len_lo_q    <= 8'd0;
            words_q     <= 17'd0;
            waddr_q     <= '0;
            bidx_q      <= 2'd0;
            wbuf_q      <= 24'd0;
            idle_q      <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
            cpu_hold_q  <= 1'b1;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q      <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            len_lo_q    <= len_lo_d;
            words_q     <= words_d;
            waddr_q     <= waddr_d;
            bidx_q      <= bidx_d;
            wbuf_q      <= wbuf_d;
            idle_q      <= idle_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_hold_q  <= cpu_hold_d;
            load_done_q <= load_done_d;
            load_err_q  <= load_err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end
endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that writes the instruction memory the CPU fetches from. It accepts a framed byte stream from a host-link receiver through a valid/ready handshake and assembles little-endian 32-bit words. It writes each word through a single-cycle memory write port at consecutive word addresses. It holds the CPU in reset until a complete, checksum-valid image has been written.

## Interface
- `ADDR_WIDTH`, 16, word-address width of the target memory; capacity is 2^ADDR_WIDTH words.
- `MAGIC`, 8'hA5, frame start byte.
- `TIMEOUT_CYCLES`, 1000000, maximum idle cycles between bytes inside a frame.

- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_data`  in  8  stream byte.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  loader accepts the byte this cycle.
- `mem_we`  out  1  one-cycle write strobe.
- `mem_addr`  out  ADDR_WIDTH  word address.
- `mem_wdata`  out  32  write data.
- `cpu_hold`  out  1  CPU reset request.
- `load_done`  out  1  sticky: last frame completed successfully.
- `load_err`  out  1  sticky: last frame aborted.

## Operation
- A byte is accepted when `in_valid && in_ready`. `in_ready` is 1 in every state; the loader never backpressures.
- Frame format: MAGIC, LEN_L, LEN_H, then LEN 4-byte words (each word LSB byte first), then CSUM.
- CSUM is the XOR of all payload bytes only. The header bytes are excluded.
- FSM states: IDLE, LEN0, LEN1, DATA, CSUM.
  - IDLE: a byte equal to MAGIC moves to LEN0. This clears `load_done` and `load_err`, sets `cpu_hold`=1, and resets the word address, byte index and checksum accumulator to 0. Any other byte is discarded.
  - LEN0: the byte becomes LEN[7:0]. Move to LEN1.
  - LEN1: the byte becomes LEN[15:8].
    - If LEN > 2^ADDR_WIDTH: error.
    - Else if LEN==0: move to CSUM.
    - Else: move to DATA.
  - DATA: the byte is shifted into the word at position byte index (0→[7:0] … 3→[31:24]) and XORed into the checksum. On byte index 3 a write is issued and the address increments. After the LEN-th word, move to CSUM.
  - CSUM:
    - Match: set `load_done`=1, drop `cpu_hold` to 0, go to IDLE.
    - Mismatch: error.
- Error: set `load_err`=1, keep `cpu_hold`=1, return to IDLE. Words already written are not rolled back.
- Timeout:
  - In LEN0, LEN1, DATA and CSUM, an idle counter clears on every accepted byte and increments otherwise.
  - When the counter reaches TIMEOUT_CYCLES-1, an error is raised.
  - The counter is held at 0 in IDLE.
- A new MAGIC byte in IDLE always restarts the frame, including after done or error. `cpu_hold` reasserts as soon as that MAGIC byte is accepted.
- Reset mid-frame aborts the load. Memory contents are unaffected; all outputs return to reset values.

## Timing
- Reset values:
  - `in_ready`=1, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - `cpu_hold`=1, `load_done`=0, `load_err`=0.
  - FSM in IDLE.
- All outputs are registered.
- `mem_we` is high exactly one cycle, the cycle after the 4th byte of a word is accepted. `mem_addr` and `mem_wdata` are stable in that cycle.
- A byte accepted in the same cycle that `mem_we` is high is processed normally. Back-to-back bytes every cycle are fully supported.
- `load_done`/`cpu_hold` update the cycle after CSUM is accepted. Because the last write strobe precedes the CSUM byte, the CPU never leaves reset before the final write.
- `load_err` rises the cycle after the offending byte, or the cycle after the timeout count is reached.
- Address arithmetic: `mem_addr` counts in words, starting at 0 for each frame. LEN == 2^ADDR_WIDTH fills memory exactly; the address wraps to 0 after the final write, with no further writes.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - The CSUM byte is expected and checked.
  - After the last word the FSM enters CSUM.
  - A LEN==0 frame still requires a CSUM byte of 0x00.
- `IMEM_LOADER_CHECKSUM_EN` undefined:
  - No CSUM byte and no checksum logic.
  - `load_done` sets and `cpu_hold` falls the cycle after the last `mem_we`.
  - A LEN==0 frame completes the cycle after LEN_H.
  - Checksum-mismatch errors cannot occur.

## Test plan
- Reset, no input: `in_ready`=1, `cpu_hold`=1, `mem_we`=0, `load_done`=0, `load_err`=0 for 100 cycles.
- Send A5 02 00 13 00 00 00 93 00 10 00 90 back-to-back: two `mem_we` pulses, addr0=0x00000013 and addr1=0x00100093. Then `load_done`=1, `cpu_hold`=0.
- Same frame with CSUM 91: both writes still occur, then `load_err`=1, `load_done`=0, `cpu_hold`=1. A following correct frame clears `load_err` and sets `load_done`.
- Send 00 FF A5 00 00 00: the leading bytes are ignored, there are zero `mem_we` pulses, and `load_done`=1. Without the macro, send A5 00 00 instead.
- Send A5 01 00 13, then idle for TIMEOUT_CYCLES (bench parameter 64): `load_err`=1, no write issued, FSM in IDLE.
- With ADDR_WIDTH=4, send A5 11 00: `load_err`=1 immediately and no writes. Send A5 10 00 with 16 words: addresses 0..15 are written and `load_done`=1.
